// File: rtl/hbridge_ctrl_if.sv
// Bundles the per-channel PWM/direction/enable/brake requests and the registered
// bridge pin drives between the PWM generators and the H-bridge controller.
interface hbridge_ctrl_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] pwm;
    logic [N_CH-1:0] dir;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] brake;
    logic [N_CH-1:0] h_bridge_in_1;
    logic [N_CH-1:0] h_bridge_in_2;
    logic [N_CH-1:0] dead_active;

    modport master (
        output pwm,
        output dir,
        output en,
        output brake,
        input  h_bridge_in_1,
        input  h_bridge_in_2,
        input  dead_active
    );

    modport slave (
        input  pwm,
        input  dir,
        input  en,
        input  brake,
        output h_bridge_in_1,
        output h_bridge_in_2,
        output dead_active
    );
endinterface

// File: rtl/hbridge_ctrl.sv
// Multi-channel H-bridge input generator: maps pwm/dir/en/brake onto the two bridge
// legs per channel and forces a dead interval of coast between different driven modes.
module hbridge_ctrl #(
    parameter int N_CH        = 2,
    parameter int DEAD_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    hbridge_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] ST_COAST = 3'd0;
    localparam logic [2:0] ST_FWD   = 3'd1;
    localparam logic [2:0] ST_REV   = 3'd2;
    localparam logic [2:0] ST_BRAKE = 3'd3;
    localparam logic [2:0] ST_DEAD  = 3'd4;

    logic [2:0]      state_q [N_CH];
    logic [2:0]      state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [2:0]      req_s   [N_CH];

    logic [N_CH-1:0] in_1_q;
    logic [N_CH-1:0] in_1_d;
    logic [N_CH-1:0] in_2_q;
    logic [N_CH-1:0] in_2_d;
    logic [N_CH-1:0] dead_q;
    logic [N_CH-1:0] dead_d;

    // Requested mode per channel: en=0 wins over brake, brake wins over dir.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            req_s[i] = ST_COAST;
            if (bus.en[i] == 1'b0) begin
                req_s[i] = ST_COAST;
            end else if (bus.brake[i] == 1'b1) begin
                req_s[i] = ST_BRAKE;
            end else if (bus.dir[i] == 1'b1) begin
                req_s[i] = ST_FWD;
            end else begin
                req_s[i] = ST_REV;
            end
        end
    end

    // Per-channel state and dead-counter next-state logic.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_COAST: begin
                    // Both legs already low, so any mode may be entered directly.
                    state_d[i] = req_s[i];
                    cnt_d[i]   = CNT_ZERO;
                end
                ST_FWD, ST_REV, ST_BRAKE: begin
                    if (req_s[i] == ST_COAST) begin
                        state_d[i] = ST_COAST;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (req_s[i] != state_q[i]) begin
                        state_d[i] = ST_DEAD;
                        cnt_d[i]   = DEAD_LOAD;
                    end else begin
                        state_d[i] = state_q[i];
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_DEAD: begin
                    // The counter never restarts; whatever is requested at expiry wins.
                    if (req_s[i] == ST_COAST) begin
                        state_d[i] = ST_COAST;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_ZERO) begin
                        state_d[i] = req_s[i];
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        state_d[i] = ST_DEAD;
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_COAST;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output mapping taken from the next state so pins change at the same edge.
    always_comb begin
        in_1_d = {N_CH{1'b0}};
        in_2_d = {N_CH{1'b0}};
        dead_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            case (state_d[i])
                ST_COAST: begin
                    in_1_d[i] = 1'b0;
                    in_2_d[i] = 1'b0;
                    dead_d[i] = 1'b0;
                end
                ST_FWD: begin
                    in_1_d[i] = bus.pwm[i];
                    in_2_d[i] = 1'b0;
                    dead_d[i] = 1'b0;
                end
                ST_REV: begin
                    in_1_d[i] = 1'b0;
                    in_2_d[i] = bus.pwm[i];
                    dead_d[i] = 1'b0;
                end
                ST_BRAKE: begin
                    in_1_d[i] = 1'b1;
                    in_2_d[i] = 1'b1;
                    dead_d[i] = 1'b0;
                end
                ST_DEAD: begin
                    in_1_d[i] = 1'b0;
                    in_2_d[i] = 1'b0;
                    dead_d[i] = 1'b1;
                end
                default: begin
                    in_1_d[i] = 1'b0;
                    in_2_d[i] = 1'b0;
                    dead_d[i] = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers; reset overrides every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_COAST;
                cnt_q[i]   <= CNT_ZERO;
            end
            in_1_q <= {N_CH{1'b0}};
            in_2_q <= {N_CH{1'b0}};
            dead_q <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            in_1_q <= in_1_d;
            in_2_q <= in_2_d;
            dead_q <= dead_d;
        end
    end

    assign bus.h_bridge_in_1 = in_1_q;
    assign bus.h_bridge_in_2 = in_2_q;
    assign bus.dead_active   = dead_q;
endmodule

// File: doc/hbridge_ctrl.md
Name: hbridge_ctrl

Overview:
- Multi-channel H-bridge input generator for the drive motors, replacing the single-channel direction selector.
- Per channel, maps a PWM, a direction, an enable and a brake request onto the two bridge inputs.
- Inserts a programmable dead interval whenever the driven mode changes, so the two legs never switch directly from one drive polarity to the other.
- Sits between the PWM generators and the motor-driver IC pins; all outputs are registered.

Parameters:
- N_CH, 2, number of independent bridge channels (>=1).
- DEAD_CYCLES, 16, clk cycles of forced coast inserted between driven modes (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pwm  in  N_CH  per-channel PWM level.
- dir  in  N_CH  per-channel direction: 1 = forward (drive in_1), 0 = reverse (drive in_2).
- en  in  N_CH  per-channel enable; 0 = coast.
- brake  in  N_CH  per-channel brake request, honoured only when en=1.
- h_bridge_in_1  out  N_CH  bridge input 1, registered.
- h_bridge_in_2  out  N_CH  bridge input 2, registered.
- dead_active  out  N_CH  1 while the channel is in its dead interval, registered.

Behaviour:
- Channels are fully independent; each channel has its own state register and dead counter of width $clog2(DEAD_CYCLES+1).
- Requested mode, evaluated each cycle:
  - en=0 → COAST
  - en=1, brake=1 → BRAKE
  - en=1, brake=0, dir=1 → FWD
  - en=1, brake=0, dir=0 → REV
- States are COAST, FWD, REV, BRAKE and DEAD.
- Output mapping, from the next state, registered at the same edge:
  - COAST: in_1=0, in_2=0
  - FWD: in_1=pwm, in_2=0
  - REV: in_1=0, in_2=pwm
  - BRAKE: in_1=1, in_2=1
  - DEAD: in_1=0, in_2=0, dead_active=1
- Latency: an input sampled at edge k is reflected on the outputs immediately after edge k (1 cycle). pwm passes through with the same 1-cycle latency.
- Reset: on rst=1 at an edge, all channels go to COAST, counters clear, and all outputs are 0. This takes priority over everything, including mid-dead-interval and mid-drive.
- Transitions:
  - COAST → any requested mode: direct, no dead interval, since both legs are already low.
  - Any state → COAST request: immediate COAST. This includes aborting a DEAD interval; the counter clears.
  - FWD/REV/BRAKE → a different driven mode: enter DEAD and load the counter with DEAD_CYCLES-1.
  - The same driven mode persisting: stay in it. pwm and dir glitches do not trigger DEAD unless the mode actually changes.
  - DEAD: decrement each cycle while the request is not COAST. When the counter is 0 at an edge, enter the currently requested mode, re-sampled at that edge.
  - Request changes among driven modes during DEAD: the counter does not restart; the latest request wins at exit.
  - Request returns to the mode held before DEAD, while in DEAD: the interval still completes.
- Dead interval length: exactly DEAD_CYCLES cycles with both outputs low and dead_active=1.
- Invariant: h_bridge_in_1 and h_bridge_in_2 are never both high except in BRAKE. BRAKE is entered only from COAST or through DEAD.
- Simultaneous events:
  - rst beats everything.
  - en=0 beats brake and dir.
  - brake beats dir.

Test Plan:
- Reset, then channel 0 en=1, dir=1, brake=0, pwm toggling 1,0,1: in_1 follows pwm with 1-cycle lag, in_2=0, dead_active=0, no dead interval because the start is from COAST.
- DEAD_CYCLES=4, channel 0 in FWD with pwm=1, dir flips to 0: exactly 4 cycles of in_1=in_2=0 with dead_active=1, then in_2=pwm.
- FWD, then brake=1: 4 dead cycles, then in_1=in_2=1. Drop en to 0 during the 2nd dead cycle: COAST on the next edge, dead_active=0.
- During a dead interval, dir toggles REV→FWD→REV: the interval ends on schedule (no restart) and the channel enters the final requested mode.
- rst asserted mid-dead on channel 1 while channel 0 is in FWD: both channels go to all outputs 0 on the next edge. Channel 1 re-enabled afterwards enters its mode directly.
- N_CH=2: channel 0 FWD pwm=1 and channel 1 REV pwm=1 simultaneously; a dir change on channel 1 does not disturb channel 0's outputs.
